// File: rtl/cash_note_accumulator.sv
// Banknote collection front-end for the bill-payment controller: validates notes, sums a session,
// offers the payment once the bill is covered and refunds on cancel. Optional macro: CASH_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no session; notes are returned, start opens a session
// COLLECT | accepting notes until the bill is covered, cancel or inactivity timeout
// OFFER   | bill covered, cash_present high, waiting for done_ack or cancel
// REFUND  | one cycle: refund pulse carries the whole collected total
module cash_note_accumulator #(
  parameter int AMT_W       = 16,
  parameter int MAX_NOTES   = 15,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] expected_amount,
  input  logic             note_valid,
  input  logic [2:0]       note_code,
  input  logic             cancel,
  input  logic             done_ack,
  output logic             cash_present,
  output logic [AMT_W-1:0] paid_amount,
  output logic [3:0]       note_count,
  output logic             note_reject,
  output logic             refund,
  output logic [AMT_W-1:0] refund_amount,
  output logic             busy
);

  localparam int SUM_W = AMT_W + 1;
  localparam logic [3:0] MAX_NOTES_C = 4'(MAX_NOTES);

  // 500 must be representable and note_count is four bits wide
  if (AMT_W < 9 || MAX_NOTES < 1 || MAX_NOTES > 15 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("cash_note_accumulator: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OFFER   = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] total;
  logic [AMT_W-1:0] expected_q;
  logic [3:0]       count;

  logic [SUM_W-1:0] note_value;
  logic             code_ok;
  logic [SUM_W-1:0] sum;
  logic             fits;
  logic             count_ok;
  logic             accept;
  logic [AMT_W-1:0] next_total;
  logic             timed_out;
  logic             abort;

  always_comb begin
    note_value = '0;
    code_ok    = 1'b1;
    case (note_code)
      3'd0:    note_value = SUM_W'(10);
      3'd1:    note_value = SUM_W'(20);
      3'd2:    note_value = SUM_W'(50);
      3'd3:    note_value = SUM_W'(100);
      3'd4:    note_value = SUM_W'(200);
      3'd5:    note_value = SUM_W'(500);
      default: code_ok    = 1'b0;
    endcase
  end

  // the extra sum bit is the overflow flag for the AMT_W-wide total
  assign sum        = {1'b0, total} + note_value;
  assign fits       = ~sum[AMT_W];
  assign count_ok   = (count < MAX_NOTES_C);
  assign accept     = (state == S_COLLECT) && !cancel && note_valid && code_ok && count_ok && fits;
  assign next_total = accept ? sum[AMT_W-1:0] : total;
  assign abort      = cancel || (!accept && timed_out && (total < expected_q));

`ifdef CASH_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] timer;

  // down-counter reloaded on start and every accepted note; terminal count is zero
  assign timed_out = (timer == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (state == S_IDLE && start) begin
      timer <= TMR_LOAD;
    end else if (state == S_COLLECT) begin
      if (accept)          timer <= TMR_LOAD;
      else if (!timed_out) timer <= timer - TMR_W'(1);
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      total         <= '0;
      expected_q    <= '0;
      count         <= '0;
      cash_present  <= 1'b0;
      note_reject   <= 1'b0;
      refund        <= 1'b0;
      refund_amount <= '0;
      busy          <= 1'b0;
    end else begin
      note_reject   <= note_valid;
      refund        <= 1'b0;
      refund_amount <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            expected_q <= expected_amount;
            total      <= '0;
            count      <= '0;
            busy       <= 1'b1;
            state      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          note_reject <= note_valid && !accept;
          if (accept) begin
            total <= next_total;
            count <= count + 4'd1;
          end
          if (abort) begin
            if (total != '0) begin
              refund        <= 1'b1;
              refund_amount <= total;
              state         <= S_REFUND;
            end else begin
              count <= '0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (next_total >= expected_q) begin
            cash_present <= 1'b1;
            state        <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (done_ack) begin
            total        <= '0;
            count        <= '0;
            cash_present <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else if (cancel) begin
            cash_present  <= 1'b0;
            refund        <= 1'b1;
            refund_amount <= total;
            state         <= S_REFUND;
          end
        end
        S_REFUND: begin
          total <= '0;
          count <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          total        <= '0;
          count        <= '0;
          cash_present <= 1'b0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  assign paid_amount = total;
  assign note_count  = count;

endmodule

// File: tb/tb_cash_note_accumulator.sv
// Bench for cash_note_accumulator: directed scenarios plus a random run checked against a
// session-level model; a 16-bit and a 10-bit instance share the same stimulus.
module tb_cash_note_accumulator;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] exp_amt;
  logic        note_valid;
  logic [2:0]  note_code;
  logic        cancel;
  logic        done_ack;

  logic        cash_w, rej_w, refund_w, busy_w;
  logic [15:0] paid_w, ref_amt_w;
  logic [3:0]  count_w;
  logic        cash_s, rej_s, refund_s, busy_s;
  logic [9:0]  paid_s, ref_amt_s;
  logic [3:0]  count_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cash_note_accumulator #(.AMT_W(16), .MAX_NOTES(15), .TIMEOUT_CYC(TMO)) u_dut (
    .clk(clk), .reset(reset), .start(start), .expected_amount(exp_amt),
    .note_valid(note_valid), .note_code(note_code), .cancel(cancel), .done_ack(done_ack),
    .cash_present(cash_w), .paid_amount(paid_w), .note_count(count_w), .note_reject(rej_w),
    .refund(refund_w), .refund_amount(ref_amt_w), .busy(busy_w)
  );

  cash_note_accumulator #(.AMT_W(10), .MAX_NOTES(15), .TIMEOUT_CYC(TMO)) u_small (
    .clk(clk), .reset(reset), .start(start), .expected_amount(exp_amt[9:0]),
    .note_valid(note_valid), .note_code(note_code), .cancel(cancel), .done_ack(done_ack),
    .cash_present(cash_s), .paid_amount(paid_s), .note_count(count_s), .note_reject(rej_s),
    .refund(refund_s), .refund_amount(ref_amt_s), .busy(busy_s)
  );

  // ---------------- session-level reference model ----------------
  localparam int P_IDLE = 0, P_COLLECT = 1, P_OFFER = 2, P_REFUND = 3;
  int m_ph[2], m_total[2], m_count[2], m_target[2], m_idle[2], m_ref_amt[2];
  bit m_rej[2], m_ref[2];

  function automatic int denom(input logic [2:0] c);
    case (c)
      3'd0: return 10;
      3'd1: return 20;
      3'd2: return 50;
      3'd3: return 100;
      3'd4: return 200;
      3'd5: return 500;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = P_IDLE; m_total[i] = 0; m_count[i] = 0; m_target[i] = 0;
      m_idle[i] = 0; m_ref_amt[i] = 0; m_rej[i] = 0; m_ref[i] = 0;
    end
  endtask

  task automatic model_abort(input int i);
    if (m_total[i] > 0) begin
      m_ph[i] = P_REFUND; m_ref[i] = 1; m_ref_amt[i] = m_total[i];
    end else begin
      m_ph[i] = P_IDLE; m_count[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int max_amt, v;
    bit ok, timeout_en;
    max_amt = (i == 0) ? 65535 : 1023;
    timeout_en = 0;
`ifdef CASH_TIMEOUT_EN
    timeout_en = 1;
`endif
    m_rej[i] = note_valid; m_ref[i] = 0; m_ref_amt[i] = 0;
    case (m_ph[i])
      P_IDLE: if (start) begin
        m_target[i] = int'(exp_amt) & max_amt;
        m_total[i] = 0; m_count[i] = 0; m_idle[i] = 0; m_ph[i] = P_COLLECT;
      end
      P_COLLECT: begin
        if (cancel) model_abort(i);
        else begin
          v = denom(note_code);
          ok = note_valid && v > 0 && m_count[i] < 15 && m_total[i] + v <= max_amt;
          m_rej[i] = note_valid && !ok;
          if (ok) begin m_total[i] += v; m_count[i]++; m_idle[i] = 0; end
          else m_idle[i]++;
          if (m_total[i] >= m_target[i]) m_ph[i] = P_OFFER;
          else if (timeout_en && m_idle[i] >= TMO) model_abort(i);
        end
      end
      P_OFFER: begin
        if (done_ack) begin m_ph[i] = P_IDLE; m_total[i] = 0; m_count[i] = 0; end
        else if (cancel) begin m_ph[i] = P_REFUND; m_ref[i] = 1; m_ref_amt[i] = m_total[i]; end
      end
      default: begin m_ph[i] = P_IDLE; m_total[i] = 0; m_count[i] = 0; end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; note_valid = 0; note_code = 0; cancel = 0; done_ack = 0;
  endtask

  task automatic open_session(input logic [15:0] amt);
    exp_amt = amt; start = 1;
    tick();
    start = 0;
  endtask

  task automatic insert(input logic [2:0] code);
    note_valid = 1; note_code = code;
    tick();
    note_valid = 0;
  endtask

  task automatic pulse_cancel();
    cancel = 1;
    tick();
    cancel = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 0; clear_inputs(); exp_amt = 0;
    #12;
    checks++; if ({cash_w, rej_w, refund_w, busy_w} !== 4'b0 || paid_w !== 16'd0 || count_w !== 4'd0 || ref_amt_w !== 16'd0) begin
      errors++; $display("FAIL reset_outputs: got cash=%b rej=%b ref=%b busy=%b paid=%0d cnt=%0d ramt=%0d, want all 0", cash_w, rej_w, refund_w, busy_w, paid_w, count_w, ref_amt_w);
    end
    #1 reset = 1;
    tick();
  endtask

  task automatic test_basic();
    open_session(16'd150);
    checks++; if (busy_w !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_w); end
    insert(3'd3);
    checks++; if (paid_w !== 16'd100 || cash_w !== 1'b0) begin errors++; $display("FAIL basic_first_note: got paid=%0d cash=%b want 100/0", paid_w, cash_w); end
    insert(3'd2);
    checks++; if (paid_w !== 16'd150 || cash_w !== 1'b1 || count_w !== 4'd2) begin errors++; $display("FAIL basic_covered: got paid=%0d cash=%b cnt=%0d want 150/1/2", paid_w, cash_w, count_w); end
    done_ack = 1; tick(); done_ack = 0;
    checks++; if (paid_w !== 16'd0 || cash_w !== 1'b0 || busy_w !== 1'b0 || count_w !== 4'd0) begin errors++; $display("FAIL basic_ack: got paid=%0d cash=%b busy=%b cnt=%0d want 0/0/0/0", paid_w, cash_w, busy_w, count_w); end
  endtask

  task automatic test_invalid_code();
    open_session(16'd300);
    insert(3'd6);
    checks++; if (rej_w !== 1'b1 || paid_w !== 16'd0) begin errors++; $display("FAIL invalid_reject: got rej=%b paid=%0d want 1/0", rej_w, paid_w); end
    insert(3'd5);
    checks++; if (rej_w !== 1'b0 || paid_w !== 16'd500 || cash_w !== 1'b1) begin errors++; $display("FAIL invalid_then_500: got rej=%b paid=%0d cash=%b want 0/500/1", rej_w, paid_w, cash_w); end
    done_ack = 1; tick(); done_ack = 0;
  endtask

  task automatic test_cancel_refund();
    open_session(16'd1000);
    insert(3'd4);
    insert(3'd2);
    pulse_cancel();
    checks++; if (refund_w !== 1'b1 || ref_amt_w !== 16'd250 || busy_w !== 1'b1) begin errors++; $display("FAIL cancel_refund: got ref=%b amt=%0d busy=%b want 1/250/1", refund_w, ref_amt_w, busy_w); end
    tick();
    checks++; if (refund_w !== 1'b0 || ref_amt_w !== 16'd0 || busy_w !== 1'b0 || count_w !== 4'd0 || paid_w !== 16'd0) begin errors++; $display("FAIL cancel_after: got ref=%b amt=%0d busy=%b cnt=%0d paid=%0d want 0/0/0/0/0", refund_w, ref_amt_w, busy_w, count_w, paid_w); end
  endtask

  task automatic test_timeout();
    int seen;
    open_session(16'd1000);
    insert(3'd1);
    seen = 0;
`ifdef CASH_TIMEOUT_EN
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      tick();
      if (refund_w === 1'b1) begin
        seen = k;
        checks++; if (ref_amt_w !== 16'd20) begin errors++; $display("FAIL timeout_amount: got %0d want 20", ref_amt_w); end
      end
    end
    checks++; if (seen != TMO) begin errors++; $display("FAIL timeout_delay: got refund %0d cycles after note, want %0d", seen, TMO); end
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (refund_w === 1'b1 && seen == 0) seen = k;
    end
    checks++; if (seen != 0 || busy_w !== 1'b1 || paid_w !== 16'd20) begin errors++; $display("FAIL no_timeout: got refund at %0d busy=%b paid=%0d want none/1/20", seen, busy_w, paid_w); end
`endif
    pulse_cancel();
    tick();
    tick();
  endtask

  task automatic test_max_notes();
    open_session(16'd65535);
    for (int n = 0; n < 15; n++) insert(3'd5);
    checks++; if (count_w !== 4'd15 || paid_w !== 16'd7500 || cash_w !== 1'b0) begin errors++; $display("FAIL max_fill: got cnt=%0d paid=%0d cash=%b want 15/7500/0", count_w, paid_w, cash_w); end
    insert(3'd0);
    checks++; if (rej_w !== 1'b1 || count_w !== 4'd15 || paid_w !== 16'd7500) begin errors++; $display("FAIL max_16th: got rej=%b cnt=%0d paid=%0d want 1/15/7500", rej_w, count_w, paid_w); end
    pulse_cancel();
    checks++; if (refund_w !== 1'b1 || ref_amt_w !== 16'd7500) begin errors++; $display("FAIL max_refund: got ref=%b amt=%0d want 1/7500", refund_w, ref_amt_w); end
    tick();
  endtask

  task automatic test_overflow();
    open_session(16'd1023);
    insert(3'd5);
    insert(3'd5);
    insert(3'd2);
    checks++; if (rej_s !== 1'b1 || paid_s !== 10'd1000) begin errors++; $display("FAIL ovf_50: got rej=%b paid=%0d want 1/1000", rej_s, paid_s); end
    insert(3'd1);
    checks++; if (rej_s !== 1'b0 || paid_s !== 10'd1020) begin errors++; $display("FAIL ovf_fit_20: got rej=%b paid=%0d want 0/1020", rej_s, paid_s); end
    insert(3'd0);
    checks++; if (rej_s !== 1'b1 || paid_s !== 10'd1020 || count_s !== 4'd3 || cash_s !== 1'b0) begin errors++; $display("FAIL ovf_10: got rej=%b paid=%0d cnt=%0d cash=%b want 1/1020/3/0", rej_s, paid_s, count_s, cash_s); end
    pulse_cancel();
    checks++; if (refund_s !== 1'b1 || ref_amt_s !== 10'd1020) begin errors++; $display("FAIL ovf_refund: got ref=%b amt=%0d want 1/1020", refund_s, ref_amt_s); end
    tick();
  endtask

  task automatic test_ack_beats_cancel();
    open_session(16'd100);
    insert(3'd3);
    checks++; if (cash_w !== 1'b1) begin errors++; $display("FAIL ack_offer: got cash=%b want 1", cash_w); end
    done_ack = 1; cancel = 1; tick(); done_ack = 0; cancel = 0;
    checks++; if (refund_w !== 1'b0 || busy_w !== 1'b0 || cash_w !== 1'b0 || paid_w !== 16'd0) begin errors++; $display("FAIL ack_cancel: got ref=%b busy=%b cash=%b paid=%0d want 0/0/0/0", refund_w, busy_w, cash_w, paid_w); end
    tick();
    checks++; if (refund_w !== 1'b0) begin errors++; $display("FAIL ack_cancel_late: got ref=%b want 0", refund_w); end
  endtask

  task automatic test_expected_zero();
    open_session(16'd0);
    checks++; if (cash_w !== 1'b0 || busy_w !== 1'b1) begin errors++; $display("FAIL zero_start: got cash=%b busy=%b want 0/1", cash_w, busy_w); end
    tick();
    checks++; if (cash_w !== 1'b1 || paid_w !== 16'd0) begin errors++; $display("FAIL zero_offer: got cash=%b paid=%0d want 1/0", cash_w, paid_w); end
    done_ack = 1; tick(); done_ack = 0;
  endtask

  task automatic test_async_reset();
    open_session(16'd1000);
    insert(3'd4);
    checks++; if (paid_w !== 16'd200 || busy_w !== 1'b1) begin errors++; $display("FAIL areset_pre: got paid=%0d busy=%b want 200/1", paid_w, busy_w); end
    #2 reset = 0;
    #1;
    checks++; if (paid_w !== 16'd0 || busy_w !== 1'b0 || count_w !== 4'd0 || cash_w !== 1'b0 || refund_w !== 1'b0) begin errors++; $display("FAIL areset_async: got paid=%0d busy=%b cnt=%0d cash=%b ref=%b want 0", paid_w, busy_w, count_w, cash_w, refund_w); end
    reset = 1;
    tick();
    checks++; if (refund_w !== 1'b0 || busy_w !== 1'b0) begin errors++; $display("FAIL areset_after: got ref=%b busy=%b want 0/0", refund_w, busy_w); end
  endtask

  task automatic test_random();
    logic [15:0] o_paid[2], o_ramt[2];
    logic [3:0]  o_cnt[2];
    logic        o_cash[2], o_rej[2], o_ref[2], o_busy[2];
    int dens, sel;
    clear_inputs();
    #2 reset = 0;
    #2 reset = 1;
    model_reset();
    tick();
    for (int seg = 0; seg < 60; seg++) begin
      dens = $urandom_range(0, 3);
      for (int c = 0; c < 50; c++) begin
        start      = ($urandom_range(0, 99) < 30);
        note_valid = ($urandom_range(0, 99) < (dens == 0 ? 5 : dens * 25));
        note_code  = 3'($urandom_range(0, 7));
        cancel     = ($urandom_range(0, 99) < 3);
        done_ack   = ($urandom_range(0, 99) < 25);
        sel = $urandom_range(0, 3);
        exp_amt = (sel == 0) ? 16'd0 : (sel == 1) ? 16'($urandom_range(10, 600)) :
                  (sel == 2) ? 16'($urandom_range(600, 3000)) : 16'($urandom_range(0, 65535));
        model_step(0);
        model_step(1);
        tick();
        o_paid[0] = paid_w;  o_ramt[0] = ref_amt_w;  o_cnt[0] = count_w;
        o_cash[0] = cash_w;  o_rej[0] = rej_w;  o_ref[0] = refund_w;  o_busy[0] = busy_w;
        o_paid[1] = {6'd0, paid_s};  o_ramt[1] = {6'd0, ref_amt_s};  o_cnt[1] = count_s;
        o_cash[1] = cash_s;  o_rej[1] = rej_s;  o_ref[1] = refund_s;  o_busy[1] = busy_s;
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (o_paid[i] !== 16'(m_total[i]) || o_cnt[i] !== 4'(m_count[i]) ||
              o_cash[i] !== (m_ph[i] == P_OFFER) || o_busy[i] !== (m_ph[i] != P_IDLE) ||
              o_rej[i] !== m_rej[i] || o_ref[i] !== m_ref[i] || o_ramt[i] !== 16'(m_ref_amt[i])) begin
            errors++;
            $display("FAIL random_inst%0d t=%0t: got paid=%0d cnt=%0d cash=%b busy=%b rej=%b ref=%b ramt=%0d want paid=%0d cnt=%0d cash=%b busy=%b rej=%b ref=%b ramt=%0d",
                     i, $time, o_paid[i], o_cnt[i], o_cash[i], o_busy[i], o_rej[i], o_ref[i], o_ramt[i],
                     m_total[i], m_count[i], m_ph[i] == P_OFFER, m_ph[i] != P_IDLE, m_rej[i], m_ref[i], m_ref_amt[i]);
          end
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    exp_amt = 0;
    test_reset();
    test_basic();
    test_invalid_code();
    test_cancel_refund();
    test_timeout();
    test_max_notes();
    test_overflow();
    test_ack_beats_cancel();
    test_expected_zero();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
